// File: rtl/wb_port_arb_pkg.sv
// Shared core constants for the register-file write-port arbiter.
package wb_port_arb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/wb_llu_fifo.sv
// Small in-order buffer for long-latency results, with per-entry WAW kill and
// a source-register busy compare for ID hazard detection.
module wb_llu_fifo
    import wb_port_arb_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  ready,
    output logic                  head_occupied,
    output logic                  head_valid,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [W-1:0]          head_data,
    output logic                  busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]      valid;
    logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
    logic [W-1:0]          data_mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    assign ready         = (count < CW'(DEPTH));
    assign head_occupied = (count != '0);
    assign head_valid    = valid[rd_ptr];
    assign head_addr     = addr_mem[rd_ptr];
    assign head_data     = data_mem[rd_ptr];

    // Kill runs before the push so a same-edge push of a matching rd stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && addr_mem[i] == kill_addr) valid[i] <= 1'b0;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && ((addr_mem[i] == rs1 && rs1 != '0) ||
                             (addr_mem[i] == rs2 && rs2 != '0)))
                busy = 1'b1;
        end
    end
endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered
// long-latency results fill idle slots, and a starved head requests a WB hold.
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN_P-1:0]     wb_reg_wdata_i,
    input  logic [REG_ADDR_W-1:0] wb_reg_waddr_i,
    input  logic                  wb_reg_we_i,
    input  logic                  llu_valid_i,
    output logic                  llu_ready_o,
    input  logic [XLEN_P-1:0]     llu_wdata_i,
    input  logic [REG_ADDR_W-1:0] llu_waddr_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    output logic                  id_rs_busy_o,
    output logic                  fc_hold_o,
    output logic [XLEN_P-1:0]     rf_wdata_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic                  rf_we_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                  push;
    logic                  pop;
    logic                  kill;
    logic                  blocked;
    logic                  head_occupied;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [XLEN_P-1:0]     head_data;
    logic [SW-1:0]         starve_cnt;

    assign push    = llu_valid_i && llu_ready_o;
    assign kill    = wb_reg_we_i && (wb_reg_waddr_i != '0);
    assign blocked = head_valid && wb_reg_we_i;
    // A killed head needs no port, so it drains even while the pipeline writes.
    assign pop     = head_occupied && (!head_valid || !wb_reg_we_i);

    wb_llu_fifo #(
        .W     (XLEN_P),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_addr     (llu_waddr_i),
        .push_data     (llu_wdata_i),
        .pop           (pop),
        .kill          (kill),
        .kill_addr     (wb_reg_waddr_i),
        .rs1           (id_rs1_addr_i),
        .rs2           (id_rs2_addr_i),
        .ready         (llu_ready_o),
        .head_occupied (head_occupied),
        .head_valid    (head_valid),
        .head_addr     (head_addr),
        .head_data     (head_data),
        .busy          (id_rs_busy_o)
    );

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = wb_reg_waddr_i;
        rf_wdata_o = wb_reg_wdata_i;
        if (wb_reg_we_i) begin
            rf_we_o = (wb_reg_waddr_i != '0);
        end else if (head_valid) begin
            rf_waddr_o = head_addr;
            rf_wdata_o = head_data;
            rf_we_o    = (head_addr != '0);
        end
        if (rst) rf_we_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            fc_hold_o  <= 1'b0;
        end else begin
            if (pop || !head_valid)
                starve_cnt <= '0;
            else if (blocked && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            if (pop)
                fc_hold_o <= 1'b0;
            else if (blocked && starve_cnt == SW'(STARVE_LIMIT - 1))
                fc_hold_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: a per-cycle vector table plus hand-written
// starvation and mid-operation reset sequences.
module tb_wb_port_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_reg_wdata_i;
    logic [4:0]  wb_reg_waddr_i;
    logic        wb_reg_we_i;
    logic        llu_valid_i;
    logic        llu_ready_o;
    logic [31:0] llu_wdata_i;
    logic [4:0]  llu_waddr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs_busy_o;
    logic        fc_hold_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  rf_waddr_o;
    logic        rf_we_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arb dut (
        .clk            (clk),
        .rst            (rst),
        .wb_reg_wdata_i (wb_reg_wdata_i),
        .wb_reg_waddr_i (wb_reg_waddr_i),
        .wb_reg_we_i    (wb_reg_we_i),
        .llu_valid_i    (llu_valid_i),
        .llu_ready_o    (llu_ready_o),
        .llu_wdata_i    (llu_wdata_i),
        .llu_waddr_i    (llu_waddr_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs_busy_o   (id_rs_busy_o),
        .fc_hold_o      (fc_hold_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_we_o        (rf_we_o)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_busy;
        logic        e_hold;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic [4:0] rs1, logic [4:0] rs2,
                                logic e_we, logic [4:0] e_addr, logic [31:0] e_data,
                                logic e_ready, logic e_busy, logic e_hold);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd;
        v.lv = lv; v.la = la; v.ld = ld; v.rs1 = rs1; v.rs2 = rs2;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_hold = e_hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic lv, input logic [4:0] la,
                         input logic [31:0] ld, input logic [4:0] rs1, input logic [4:0] rs2);
        rst = r; wb_reg_we_i = we; wb_reg_waddr_i = wa; wb_reg_wdata_i = wd;
        llu_valid_i = lv; llu_waddr_i = la; llu_wdata_i = ld;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        // Expectations describe the combinational outputs during the cycle,
        // before that cycle's edge updates state.
        vecs[0]  = mk(1, 0, 0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     1, 0, 0);
        // single LLU result written the cycle after push
        vecs[1]  = mk(0, 0, 0, 0,     1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,     0, 0, 0,     5, 0,   1, 5, 32'hDEADBEEF, 1, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0,     0, 0, 0,     5, 0,   0, 0, 0,     1, 0, 0);
        // WAW kill: older rd3 killed, same-cycle push of rd3 survives
        vecs[4]  = mk(0, 1, 9, 32'h99, 1, 3, 32'h33, 3, 0, 1, 9, 32'h99, 1, 0, 0);
        vecs[5]  = mk(0, 1, 3, 32'h11, 1, 3, 32'h44, 3, 0, 1, 3, 32'h11, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0,     0, 0, 0,     3, 0,   0, 0, 0,     0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0,     3, 0,   1, 3, 32'h44, 1, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0,     0, 0, 0,     3, 0,   0, 0, 0,     1, 0, 0);
        // fill to full with port blocked, then drain with pop+push across wrap
        vecs[9]  = mk(0, 1, 10, 32'hA0, 1, 12, 32'hC1, 0, 0, 1, 10, 32'hA0, 1, 0, 0);
        vecs[10] = mk(0, 1, 11, 32'hB0, 1, 13, 32'hC2, 0, 0, 1, 11, 32'hB0, 1, 0, 0);
        vecs[11] = mk(0, 1, 10, 32'hA1, 1, 14, 32'hC9, 13, 12, 1, 10, 32'hA1, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0,   1, 12, 32'hC1, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,     1, 14, 32'hC3, 0, 0, 1, 13, 32'hC2, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0,   1, 14, 32'hC3, 1, 0, 0);
        // x0 LLU result consumed silently, x0 pipeline write suppressed
        vecs[15] = mk(0, 0, 0, 0,     1, 0, 32'h55, 0, 0,  0, 0, 0,     1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     1, 0, 0);
        vecs[17] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     1, 0, 0);
        vecs[18] = mk(0, 1, 0, 32'h77, 0, 0, 0,    0, 0,   0, 0, 0,     1, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].lv,
                  vecs[i].la, vecs[i].ld, vecs[i].rs1, vecs[i].rs2);
            #2;
            chk($sformatf("v%0d rf_we", i), 32'(rf_we_o), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr_o), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d rf_wdata", i), rf_wdata_o, vecs[i].e_data);
            end
            chk($sformatf("v%0d llu_ready", i), 32'(llu_ready_o), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d rs_busy", i), 32'(id_rs_busy_o), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d fc_hold", i), 32'(fc_hold_o), 32'(vecs[i].e_hold));
        end

        // Starvation: rd7 blocked by continuous pipeline writes.
        @(negedge clk);
        drive(0, 1, 1, 32'h100, 1, 7, 32'h77, 0, 0);
        found = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            drive(0, 1, 1, 32'h100 + k, 0, 0, 0, 0, 0);
            #2;
            if (fc_hold_o) begin
                found = k;
                break;
            end
        end
        chk("starve hold cycle", found, 5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("starve rf_we", 32'(rf_we_o), 1);
        chk("starve rf_waddr", 32'(rf_waddr_o), 7);
        chk("starve rf_wdata", rf_wdata_o, 32'h77);
        chk("starve hold during pop", 32'(fc_hold_o), 1);
        @(negedge clk);
        #2;
        chk("starve hold cleared", 32'(fc_hold_o), 0);
        chk("starve no extra write", 32'(rf_we_o), 0);

        // Reset with two queued entries and hold asserted.
        @(negedge clk);
        drive(0, 1, 1, 32'h200, 1, 20, 32'hD0, 0, 0);
        @(negedge clk);
        drive(0, 1, 1, 32'h201, 1, 21, 32'hD1, 0, 0);
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive(0, 1, 1, 32'h300 + k, 0, 0, 0, 20, 21);
            #2;
            if (fc_hold_o) begin
                found = k;
                break;
            end
        end
        chk("rst hold before", found, 4);
        chk("rst full before", 32'(llu_ready_o), 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 20, 21);
        #2;
        chk("rst rf_we forced", 32'(rf_we_o), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 20, 21);
        #2;
        chk("rst llu_ready", 32'(llu_ready_o), 1);
        chk("rst fc_hold", 32'(fc_hold_o), 0);
        chk("rst rs_busy", 32'(id_rs_busy_o), 0);
        chk("rst rf_we", 32'(rf_we_o), 0);
        @(negedge clk);
        #2;
        chk("rst rf_we later", 32'(rf_we_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
